// File: rtl/dffsr_pipe_pkg.sv
// dffsr_pipe_pkg: shared constants, stage record and width helpers for the
// dffsr_pipe staging element and its stage sub-module.
package dffsr_pipe_pkg;

    // Default geometry and per-bit fill values for clear and preset.
    localparam int   DEF_WIDTH   = 2;
    localparam logic DEF_CLR_BIT = 1'b0;
    localparam logic DEF_PRE_BIT = 1'b1;

    // Stage record at default width; the stage module mirrors this layout
    // at its own WIDTH.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Occupancy counter width: must be able to hold the value DEPTH.
    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffsr_pipe_stage.sv
// dffsr_pipe_stage: one data/valid register of one channel, with synchronous
// clear (highest priority), preset, and a load strobe from the top.
module dffsr_pipe_stage
    import dffsr_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{DEF_CLR_BIT}},
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{DEF_PRE_BIT}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_w_t;

    stage_w_t r;

    // clr > pre > load; preset only loads data, it never creates a valid entry.
    always_ff @(posedge clk) begin
        if (clr) begin
            r.valid <= 1'b0;
            r.data  <= CLR_VAL;
        end else if (pre) begin
            r.valid <= 1'b0;
            r.data  <= PRE_VAL;
        end else if (load) begin
            r.valid <= v_in;
            r.data  <= d_in;
        end
    end

    assign d_out = r.data;
    assign v_out = r.valid;

endmodule

// File: rtl/dffsr_pipe.sv
// dffsr_pipe: CHAN independent WIDTH x DEPTH register pipelines with valid
// bits, synchronous clear/preset, shared advance enable and per-channel
// occupancy counters.
// Optional feature macro: DFFSR_PIPE_COLLAPSE_EN (bubble-collapsing stages).
module dffsr_pipe
    import dffsr_pipe_pkg::*;
#(
    parameter int               WIDTH   = 2,
    parameter int               DEPTH   = 3,
    parameter int               CHAN    = 2,
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{DEF_CLR_BIT}},
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{DEF_PRE_BIT}},
    localparam int              CW      = occ_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  pre,
    input  logic                  en,
    input  logic [CHAN-1:0]       in_valid,
    input  logic [CHAN*WIDTH-1:0] d,
    output logic [CHAN-1:0]       in_ready,
    output logic [CHAN*WIDTH-1:0] q,
    output logic [CHAN-1:0]       out_valid,
    output logic [CHAN*CW-1:0]    occ
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("dffsr_pipe: DEPTH must be at least 1");
    end

    for (genvar c = 0; c < CHAN; c++) begin : g_chan
        logic [WIDTH-1:0] dat [DEPTH];
        logic [DEPTH-1:0] vld;
        logic [DEPTH-1:0] ld;
        logic [CW-1:0]    occ_r;
        logic             accept;
        logic             leave;

`ifdef DFFSR_PIPE_COLLAPSE_EN
        // Load chain built from the output end: a stage loads when it is empty
        // or its successor loads, so bubbles get squeezed out even when en=0.
        always_comb begin
            logic [DEPTH-1:0] l;
            l = '0;
            l[DEPTH-1] = en | ~vld[DEPTH-1];
            for (int i = DEPTH - 2; i >= 0; i--) begin
                l[i] = ~vld[i] | l[i+1];
            end
            ld = l;
        end
`else
        assign ld = {DEPTH{en}};
`endif

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] src_d;
            logic             src_v;

            if (i == 0) begin : g_head
                assign src_d = d[c*WIDTH +: WIDTH];
                assign src_v = in_valid[c];
            end else begin : g_body
                assign src_d = dat[i-1];
                assign src_v = vld[i-1];
            end

            dffsr_pipe_stage #(
                .WIDTH   (WIDTH),
                .CLR_VAL (CLR_VAL),
                .PRE_VAL (PRE_VAL)
            ) u_stage (
                .clk   (clk),
                .clr   (clr),
                .pre   (pre),
                .load  (ld[i]),
                .d_in  (src_d),
                .v_in  (src_v),
                .d_out (dat[i]),
                .v_out (vld[i])
            );
        end

        // Stage0 loading is exactly "this channel accepts input this cycle".
        assign in_ready[c] = ld[0];
        assign accept      = in_valid[c] & ld[0];
        assign leave       = vld[DEPTH-1] & en;

        // Occupancy tracks entries in minus entries consumed; packing moves
        // words between stages without changing the count.
        always_ff @(posedge clk) begin
            if (clr || pre) begin
                occ_r <= '0;
            end else begin
                occ_r <= occ_r + CW'(accept) - CW'(leave);
            end
        end

        assign q[c*WIDTH +: WIDTH] = dat[DEPTH-1];
        assign out_valid[c]        = vld[DEPTH-1];
        assign occ[c*CW +: CW]     = occ_r;

        // Counter must always equal the number of valid stages.
        always @(posedge clk) begin
            if (!clr) begin
                assert (int'(occ_r) == $countones(vld))
                    else $error("dffsr_pipe: occ %0d disagrees with valid stages %b", occ_r, vld);
            end
        end
    end

endmodule
